// File: rtl/usbf_tx_fifo_sched.sv
// usbf_tx_fifo_sched: w_clk-domain write-side scheduler for the endpoint TX async FIFO.
// Round-robin grants one endpoint packet at a time and streams its bytes into the FIFO.
// Zero-length packets are written as a single tagged entry. An abort flushes the write side.
module usbf_tx_fifo_sched #(
    parameter int unsigned NUM_EP = 4,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned LEN_W  = 11
) (
    input  logic                      rst_n,
    input  logic                      w_clk,
    input  logic [NUM_EP-1:0]         req,
    input  logic [NUM_EP*LEN_W-1:0]   len,
    output logic [NUM_EP-1:0]         gnt,
    input  logic [WIDTH-1:0]          src_data,
    input  logic                      src_valid,
    output logic                      src_ready,
    input  logic                      abort,
    input  logic                      fifo_full,
    output logic                      fifo_w_en,
    output logic [WIDTH+1:0]          fifo_din,
    output logic                      fifo_w_flush,
    output logic                      done,
    output logic [$clog2(NUM_EP)-1:0] done_ep,
    output logic                      done_abort,
    output logic                      busy
);

    localparam int unsigned EP_W = $clog2(NUM_EP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t            state;
    logic [EP_W-1:0]   rr_ptr;
    logic [EP_W-1:0]   gnt_idx;
    logic [LEN_W-1:0]  cnt;
    logic              zlp_f;

    logic              win_vld;
    logic [EP_W-1:0]   win_idx;
    logic [EP_W-1:0]   cand;
    logic [LEN_W-1:0]  win_len;
    logic              last_beat;
    logic              xfer_end;

    // Round-robin search: first requesting endpoint above rr_ptr, wrapping.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= NUM_EP; i++) begin
            cand = EP_W'((32'(rr_ptr) + i) % NUM_EP);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Length of the winning endpoint, captured at grant.
    always_comb begin
        win_len = '0;
        for (int unsigned i = 0; i < NUM_EP; i++) begin
            if (win_idx == EP_W'(i)) begin
                win_len = len[i*LEN_W +: LEN_W];
            end
        end
    end

    assign last_beat = (cnt == LEN_W'(1));

    // FIFO write port and source handshake; abort suppresses any same-cycle beat.
    always_comb begin
        src_ready = 1'b0;
        fifo_w_en = 1'b0;
        fifo_din  = '0;
        if (state == ST_XFER && !abort) begin
            if (zlp_f) begin
                fifo_w_en = !fifo_full;
                fifo_din  = {1'b1, 1'b1, {WIDTH{1'b0}}};
            end else begin
                src_ready = !fifo_full;
                fifo_w_en = src_valid && !fifo_full;
                fifo_din  = {1'b0, last_beat, src_data};
            end
        end
    end

    // Final write of the packet has been accepted by the FIFO this cycle.
    assign xfer_end = (state == ST_XFER) && fifo_w_en && (zlp_f || last_beat);

    // Scheduler FSM with registered grant, status and flush outputs.
    always_ff @(posedge w_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= EP_W'(NUM_EP - 1);
            gnt_idx      <= '0;
            cnt          <= '0;
            zlp_f        <= 1'b0;
            gnt          <= '0;
            fifo_w_flush <= 1'b0;
            done         <= 1'b0;
            done_ep      <= '0;
            done_abort   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            fifo_w_flush <= 1'b0;
            done         <= 1'b0;
            done_abort   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        state   <= ST_XFER;
                        busy    <= 1'b1;
                        gnt     <= NUM_EP'(1) << win_idx;
                        gnt_idx <= win_idx;
                        cnt     <= win_len;
                        zlp_f   <= (win_len == '0);
                    end
                end
                ST_XFER: begin
                    if (abort) begin
                        state        <= ST_FLUSH;
                        fifo_w_flush <= 1'b1;
                    end else if (xfer_end) begin
                        state   <= ST_DONE;
                        done    <= 1'b1;
                        done_ep <= gnt_idx;
                        gnt     <= '0;
                    end else if (fifo_w_en && !zlp_f) begin
                        cnt <= cnt - LEN_W'(1);
                    end
                end
                ST_FLUSH: begin
                    state      <= ST_DONE;
                    done       <= 1'b1;
                    done_abort <= 1'b1;
                    done_ep    <= gnt_idx;
                    gnt        <= '0;
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    rr_ptr <= gnt_idx;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usbf_tx_fifo_sched.sv
// Directed self-checking bench for usbf_tx_fifo_sched.
module tb_usbf_tx_fifo_sched;

    localparam int unsigned NUM_EP = 4;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned LEN_W  = 11;

    logic                    rst_n;
    logic                    w_clk;
    logic [NUM_EP-1:0]       req;
    logic [NUM_EP*LEN_W-1:0] len;
    logic [NUM_EP-1:0]       gnt;
    logic [WIDTH-1:0]        src_data;
    logic                    src_valid;
    logic                    src_ready;
    logic                    abort;
    logic                    fifo_full;
    logic                    fifo_w_en;
    logic [WIDTH+1:0]        fifo_din;
    logic                    fifo_w_flush;
    logic                    done;
    logic [1:0]              done_ep;
    logic                    done_abort;
    logic                    busy;

    usbf_tx_fifo_sched #(.NUM_EP(NUM_EP), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .rst_n(rst_n), .w_clk(w_clk), .req(req), .len(len), .gnt(gnt),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .abort(abort), .fifo_full(fifo_full), .fifo_w_en(fifo_w_en),
        .fifo_din(fifo_din), .fifo_w_flush(fifo_w_flush), .done(done),
        .done_ep(done_ep), .done_abort(done_abort), .busy(busy)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int t0 = 0;
    int rdy_cnt = 0;
    int flush_cnt = 0;
    int flush_cyc = 0;
    int full_wr_cnt = 0;
    int flush_before = 0;
    int done_before = 0;
    logic       acc_pend = 1'b0;
    logic [7:0] src_byte = 8'h10;
    logic [7:0] base;
    logic [NUM_EP-1:0] prev_gnt = '0;

    logic [WIDTH+1:0]  wr_q[$];
    int                wr_cyc_q[$];
    int                done_ep_q[$];
    logic              done_ab_q[$];
    int                done_cyc_q[$];
    logic [NUM_EP-1:0] gnt_q[$];

    assign src_data = src_byte;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic clr();
        wr_q.delete();
        wr_cyc_q.delete();
        done_ep_q.delete();
        done_ab_q.delete();
        done_cyc_q.delete();
        gnt_q.delete();
        rdy_cnt   = 0;
        flush_cnt = 0;
    endtask

    // Cycle counter and source byte sequencer (advances on an accepted beat).
    initial forever begin
        @(posedge w_clk);
        cyc++;
        if (acc_pend) src_byte++;
    end

    // Observe outputs mid-cycle, away from the active edge.
    initial forever begin
        @(negedge w_clk);
        acc_pend = src_valid && src_ready;
        if (fifo_w_en) begin
            wr_q.push_back(fifo_din);
            wr_cyc_q.push_back(cyc);
        end
        if (fifo_w_en && fifo_full) full_wr_cnt++;
        if (src_ready) rdy_cnt++;
        if (fifo_w_flush) begin
            flush_cnt++;
            flush_cyc = cyc;
        end
        if (done) begin
            done_ep_q.push_back(int'(done_ep));
            done_ab_q.push_back(done_abort);
            done_cyc_q.push_back(cyc);
        end
        if (gnt != prev_gnt && gnt != '0) gnt_q.push_back(gnt);
        prev_gnt = gnt;
    end

    initial begin
        rst_n     = 1'b0;
        req       = '0;
        len       = '0;
        src_valid = 1'b0;
        abort     = 1'b0;
        fifo_full = 1'b0;
        for (int i = 0; i < int'(NUM_EP); i++) len[i*LEN_W +: LEN_W] = LEN_W'(2);

        // Reset with all requests pending
        req       = 4'b1111;
        src_valid = 1'b1;
        repeat (3) step();
        @(negedge w_clk);
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_done_ep", 32'(done_ep), 32'h0);
        check("rst_done_abort", 32'(done_abort), 32'h0);
        check("rst_flush", 32'(fifo_w_flush), 32'h0);
        check("rst_w_en", 32'(fifo_w_en), 32'h0);
        check("rst_din", 32'(fifo_din), 32'h0);
        check("rst_src_ready", 32'(src_ready), 32'h0);

        step();
        rst_n = 1'b1;
        clr();
        t0 = cyc;
        @(negedge w_clk);
        check("rel_gnt_c0", 32'(gnt), 32'h0);
        step();
        @(negedge w_clk);
        check("rel_gnt_c1", 32'(gnt), 32'h1);
        check("rel_busy_c1", 32'(busy), 32'h1);

        // Round robin over all four endpoints, len 2 each
        for (int k = 0; k < 80; k++) begin
            step();
            if (gnt_q.size() >= 5) req = '0;
            if (done_ep_q.size() >= 5) break;
        end
        req = '0;
        check("rr_done_cnt", 32'(done_ep_q.size()), 32'd5);
        check("rr_gnt_cnt", 32'(gnt_q.size()), 32'd5);
        if (gnt_q.size() == 5) begin
            check("rr_gnt0", 32'(gnt_q[0]), 32'h1);
            check("rr_gnt1", 32'(gnt_q[1]), 32'h2);
            check("rr_gnt2", 32'(gnt_q[2]), 32'h4);
            check("rr_gnt3", 32'(gnt_q[3]), 32'h8);
            check("rr_gnt4", 32'(gnt_q[4]), 32'h1);
        end
        if (done_ep_q.size() == 5) begin
            for (int i = 0; i < 5; i++) begin
                check($sformatf("rr_done_ep%0d", i), 32'(done_ep_q[i]), 32'(i % 4));
                check($sformatf("rr_done_ab%0d", i), 32'(done_ab_q[i]), 32'h0);
            end
        end
        check("rr_wr_cnt", 32'(wr_q.size()), 32'd10);
        if (wr_q.size() == 10) begin
            for (int i = 0; i < 10; i++) begin
                check($sformatf("rr_wr%0d", i), 32'(wr_q[i]),
                      {22'h0, 1'b0, 1'(i % 2), 8'(8'h10 + i)});
            end
        end
        repeat (2) step();

        // Zero-length packet on endpoint 2
        clr();
        len[2*LEN_W +: LEN_W] = '0;
        req = 4'b0100;
        t0 = cyc;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done_ep_q.size() != 0) begin
                req = '0;
                break;
            end
        end
        check("zlp_done_cnt", 32'(done_ep_q.size()), 32'd1);
        check("zlp_wr_cnt", 32'(wr_q.size()), 32'd1);
        check("zlp_rdy_cnt", 32'(rdy_cnt), 32'd0);
        if (wr_q.size() == 1) begin
            check("zlp_din", 32'(wr_q[0]), 32'h300);
            check("zlp_wr_cyc", 32'(wr_cyc_q[0] - t0), 32'd1);
        end
        if (done_ep_q.size() == 1) begin
            check("zlp_done_ep", 32'(done_ep_q[0]), 32'd2);
            check("zlp_done_cyc", 32'(done_cyc_q[0] - t0), 32'd2);
        end
        repeat (2) step();

        // Back-pressure: len 5, fifo_full on relative cycles 2..4
        clr();
        len[0*LEN_W +: LEN_W] = LEN_W'(5);
        base = src_byte;
        req = 4'b0001;
        t0 = cyc;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done_ep_q.size() != 0) begin
                req = '0;
                fifo_full = 1'b0;
                break;
            end
            fifo_full = (cyc - t0 >= 2) && (cyc - t0 <= 4);
        end
        fifo_full = 1'b0;
        check("bp_done_cnt", 32'(done_ep_q.size()), 32'd1);
        check("bp_wr_cnt", 32'(wr_q.size()), 32'd5);
        if (wr_q.size() == 5) begin
            check("bp_wr_cyc0", 32'(wr_cyc_q[0] - t0), 32'd1);
            for (int i = 1; i < 5; i++)
                check($sformatf("bp_wr_cyc%0d", i), 32'(wr_cyc_q[i] - t0), 32'(i + 4));
            for (int i = 0; i < 5; i++)
                check($sformatf("bp_wr%0d", i), 32'(wr_q[i]),
                      {22'h0, 1'b0, 1'(i == 4), 8'(base + 8'(i))});
        end
        if (done_ep_q.size() == 1) begin
            check("bp_done_cyc", 32'(done_cyc_q[0] - t0), 32'd9);
            check("bp_done_ep", 32'(done_ep_q[0]), 32'd0);
        end
        repeat (2) step();

        // Abort after the third beat of a 10-byte packet on endpoint 2
        clr();
        len[2*LEN_W +: LEN_W] = LEN_W'(10);
        req = 4'b0100;
        t0 = cyc;
        for (int k = 0; k < 40; k++) begin
            step();
            abort = (cyc - t0 == 4);
            if (done_ep_q.size() != 0) begin
                req = '0;
                break;
            end
        end
        abort = 1'b0;
        check("ab_wr_cnt", 32'(wr_q.size()), 32'd3);
        check("ab_flush_cnt", 32'(flush_cnt), 32'd1);
        check("ab_flush_cyc", 32'(flush_cyc - t0), 32'd5);
        check("ab_done_cnt", 32'(done_ep_q.size()), 32'd1);
        if (done_ep_q.size() == 1) begin
            check("ab_done_cyc", 32'(done_cyc_q[0] - t0), 32'd6);
            check("ab_done_abort", 32'(done_ab_q[0]), 32'h1);
            check("ab_done_ep", 32'(done_ep_q[0]), 32'd2);
        end
        repeat (2) step();
        @(negedge w_clk);
        check("ab_idle_busy", 32'(busy), 32'h0);

        // Abort pulsed in IDLE is ignored
        flush_before = flush_cnt;
        done_before  = done_ep_q.size();
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        @(negedge w_clk);
        check("idle_ab_flush", 32'(flush_cnt), 32'(flush_before));
        check("idle_ab_done", 32'(done_ep_q.size()), 32'(done_before));
        check("idle_ab_busy", 32'(busy), 32'h0);
        check("idle_ab_gnt", 32'(gnt), 32'h0);

        // Source stall: src_valid toggles, len 4 on endpoint 1
        clr();
        len[1*LEN_W +: LEN_W] = LEN_W'(4);
        req = 4'b0010;
        src_valid = 1'b0;
        t0 = cyc;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done_ep_q.size() != 0) begin
                req = '0;
                break;
            end
            src_valid = ((cyc - t0) % 2 == 1);
        end
        src_valid = 1'b1;
        check("st_wr_cnt", 32'(wr_q.size()), 32'd4);
        if (wr_q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("st_wr_cyc%0d", i), 32'(wr_cyc_q[i] - t0), 32'(2 * i + 1));
                check($sformatf("st_last%0d", i), 32'(wr_q[i][WIDTH]), 32'(i == 3));
            end
        end
        check("st_done_cnt", 32'(done_ep_q.size()), 32'd1);
        if (done_ep_q.size() == 1) begin
            check("st_done_cyc", 32'(done_cyc_q[0] - t0), 32'd8);
            check("st_done_ep", 32'(done_ep_q[0]), 32'd1);
        end
        repeat (2) step();

        check("no_write_when_full", 32'(full_wr_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/usbf_tx_fifo_sched.md
# usbf_tx_fifo_sched

Write-side scheduler for the endpoint TX async FIFO, in the `w_clk` domain. It arbitrates round-robin between `NUM_EP` endpoint packet requests. It streams the granted endpoint's bytes from a shared source bus into the FIFO write port, tagging the last byte and zero-length packets. It also aborts an in-flight packet by flushing the FIFO write side.

## Interface
Parameters:
- `NUM_EP`, 4: number of requesting endpoints, 2..16.
- `WIDTH`, 8: data byte width.
- `LEN_W`, 11: packet length field width, in bytes.

Ports:
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `w_clk`, input, 1: clock; all logic is in this domain.
- `req`, input, NUM_EP: per-endpoint packet request, level; held until `done` for that endpoint.
- `len`, input, NUM_EP*LEN_W: per-endpoint packet length, slice i = `len[i*LEN_W +: LEN_W]`; sampled at grant.
- `gnt`, output, NUM_EP: one-hot registered grant; the external source mux selects on it.
- `src_data`, input, WIDTH: byte from the granted endpoint buffer.
- `src_valid`, input, 1: `src_data` valid.
- `src_ready`, output, 1: byte accepted when `src_valid && src_ready`.
- `abort`, input, 1: single-cycle pulse; abort the in-flight packet.
- `fifo_full`, input, 1: registered `full` of the FIFO.
- `fifo_w_en`, output, 1: FIFO write enable.
- `fifo_din`, output, WIDTH+2: `{zlp, last, data}` FIFO write entry.
- `fifo_w_flush`, output, 1: FIFO write-side flush, one-cycle pulse.
- `done`, output, 1: one-cycle pulse at packet end.
- `done_ep`, output, $clog2(NUM_EP): endpoint index that finished; valid with `done`.
- `done_abort`, output, 1: set with `done` if the packet was aborted.
- `busy`, output, 1: high in any state other than IDLE.

## Operation
States are IDLE, XFER, DONE and FLUSH.
- **IDLE:**
  - If any `req` bit is set, the winner is the first set bit searching upward from `rr_ptr+1`, modulo NUM_EP.
  - Next cycle: `gnt` = one-hot of the winner, `cnt` = `len[winner]`, `zlp_f` = (len==0), and the state moves to XFER.
  - `abort` is ignored in IDLE.
- **XFER, normal packet:**
  - `src_ready` = `!fifo_full`.
  - `fifo_w_en` = `src_valid && !fifo_full`.
  - `fifo_din` = `{1'b0, cnt==1, src_data}`.
  - On each accepted beat, `cnt` decrements. The beat with `cnt==1` goes to DONE.
- **XFER, zero-length packet (`zlp_f`):**
  - `src_ready` = 0.
  - `fifo_w_en` = `!fifo_full`.
  - `fifo_din` = `{1'b1, 1'b1, {WIDTH{1'b0}}}`.
  - Goes to DONE once written.
- **XFER, abort:**
  - `abort` in XFER has priority over a same-cycle beat: no write, `src_ready`=0, and the state goes to FLUSH.
- **FLUSH:** `fifo_w_flush`=1 for one cycle, then DONE with `done_abort`=1.
- **DONE:**
  - `done`=1, `done_ep` = the granted index, `gnt` cleared, `rr_ptr` = the granted index.
  - Then IDLE.
- **Request changes:** deassertion or change of `req`/`len` after grant is ignored until DONE.
- **Arithmetic:** `cnt` is LEN_W bits and never underflows, because the exit happens at `cnt==1`.
- **Reset values:**
  - `rr_ptr` resets to NUM_EP-1, so endpoint 0 has first priority.
  - Outputs: `gnt`=0, `src_ready`=0, `fifo_w_en`=0, `fifo_din`=0, `fifo_w_flush`=0, `done`=0, `done_ep`=0, `done_abort`=0, `busy`=0.
- **Reset mid-packet:** the state returns to IDLE with no flush pulse; the FIFO is reset by the same `rst_n`.

## Timing
- **Grant latency:** `req` seen at cycle 0 gives `gnt` and XFER at cycle 1; the first write is possible at cycle 1.
- **Throughput:** one byte per cycle while `src_valid` is high and `fifo_full` is low. A packet of length L with no stalls writes on cycles 1..L, pulses `done` at L+1, and is IDLE at L+2.
- **Next grant:** earliest at L+3.
- **Back-pressure:** `fifo_full` stalls writes combinationally in the same cycle. The FIFO also gates on `full`, so a write is never lost or duplicated.
- **Abort:** `abort` at cycle t in XFER gives `fifo_w_flush` at t+1, `done`+`done_abort` at t+2, and IDLE at t+3.
- **Outputs:** `src_ready`, `fifo_w_en` and `fifo_din` are combinational from state, counter and inputs. `gnt`, `done*`, `fifo_w_flush` and `busy` are registered.

## Test plan
- **Reset:** hold `rst_n`=0 with `req`=4'b1111 → all outputs 0. After release, `gnt`=4'b0001 one cycle later.
- **Round-robin:** all `req` held, each `len`=2, source always valid → grant order ep0, ep1, ep2, ep3, ep0. Exactly 2 writes per packet, `last`=1 on the second write only, and `done_ep` sequence 0,1,2,3.
- **Zero-length packet:** `req`=4'b0100 with len2=0 → exactly one write of `fifo_din`=`{1,1,8'h00}`, `src_ready` never high, and `done_ep`=2.
- **Back-pressure:** len=5 with `fifo_full` high on cycles 2–4 → no `fifo_w_en` in those cycles, the 5 bytes are written in order, and `done` comes 3 cycles later than the stall-free case.
- **Abort:** len=10, `abort` after the 3rd beat → 3 writes only, one `fifo_w_flush` pulse, then `done`=1 and `done_abort`=1. An `abort` pulsed in IDLE has no effect.
- **Source stall:** `src_valid` toggling 1,0,1,0 with len=4 → writes only in valid cycles, and `last` is set on the 4th write.
